// File: rtl/mbist_alg_scheduler.sv
// MBIST algorithm scheduler: runs each selected algorithm on the controller in turn and collects per-algorithm fail results.
// Optional watchdog on each run is enabled by defining MBIST_SCHED_WDOG_EN.
module mbist_alg_scheduler #(
    parameter int ALGNUM  = 3,
    parameter int RST_CYC = 4,
    parameter int WDOG_W  = 16
) (
    input  logic              bist_clk,
    input  logic              rst_h,
    input  logic              start_h,
    input  logic [ALGNUM:0]   alg_mask,
    input  logic              tst_done,
    input  logic              fail_h,
    output logic              test_h,
    output logic              ctl_rst_l,
    output logic [ALGNUM:0]   tst_algsel,
    output logic              busy,
    output logic              sess_done,
    output logic [ALGNUM:0]   fail_map,
    output logic              timeout_err
);

    typedef logic [ALGNUM:0] vec_t;
    typedef enum logic [2:0] {S_IDLE, S_RST, S_RUN, S_LOG, S_DONE} state_t;

    if (RST_CYC < 1 || RST_CYC > 15 || WDOG_W < 2) begin : g_param_check
        $error("mbist_alg_scheduler: illegal RST_CYC or WDOG_W");
    end

    state_t     state_q, state_d;
    vec_t       pend_q, pend_d;
    vec_t       cur_q, cur_d;
    vec_t       fmap_q, fmap_d;
    vec_t       algsel_q, algsel_d;
    logic [3:0] rcnt_q, rcnt_d;
    logic       test_q, test_d;
    logic       ctl_q, ctl_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
`ifdef MBIST_SCHED_WDOG_EN
    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic              wdog_term;
    logic              tmo_q, tmo_d;
`endif

    function automatic vec_t lowest(input vec_t v);
        return v & (~v + vec_t'(1));
    endfunction

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        cur_d   = cur_q;
        fmap_d  = fmap_q;
        rcnt_d  = rcnt_q;
`ifdef MBIST_SCHED_WDOG_EN
        tmo_d     = tmo_q;
        wdog_d    = '0;
        wdog_term = &(wdog_q + WDOG_W'(1));
        if (state_q == S_RUN) wdog_d = wdog_q + WDOG_W'(1);
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_h) begin
                    fmap_d = '0;
`ifdef MBIST_SCHED_WDOG_EN
                    tmo_d  = 1'b0;
`endif
                    rcnt_d = '0;
                    if (alg_mask != '0) begin
                        pend_d  = alg_mask;
                        cur_d   = lowest(alg_mask);
                        state_d = S_RST;
                    end else begin
                        pend_d  = '0;
                        cur_d   = '0;
                        state_d = S_DONE;
                    end
                end
            end
            S_RST: begin
                if (rcnt_q == 4'(RST_CYC - 1)) begin
                    rcnt_d  = '0;
                    state_d = S_RUN;
                end else begin
                    rcnt_d = rcnt_q + 4'd1;
                end
            end
            S_RUN: begin
                if (fail_h) fmap_d = fmap_q | cur_q;
                if (tst_done) begin
                    state_d = S_LOG;
                end
`ifdef MBIST_SCHED_WDOG_EN
                else if (wdog_term) begin
                    fmap_d  = fmap_q | cur_q;
                    tmo_d   = 1'b1;
                    state_d = S_LOG;
                end
`endif
            end
            S_LOG: begin
                pend_d = pend_q & ~cur_q;
                rcnt_d = '0;
                if (pend_d != '0) begin
                    cur_d   = lowest(pend_d);
                    state_d = S_RST;
                end else begin
                    cur_d   = '0;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state so they leave the flops aligned with the state.
        test_d   = (state_d == S_RUN);
        ctl_d    = (state_d != S_RST);
        busy_d   = (state_d == S_RST) || (state_d == S_RUN) || (state_d == S_LOG);
        done_d   = (state_d == S_DONE);
        algsel_d = busy_d ? cur_d : '0;
    end

    always_ff @(posedge bist_clk or posedge rst_h) begin
        if (rst_h) begin
            state_q  <= S_IDLE;
            pend_q   <= '0;
            cur_q    <= '0;
            fmap_q   <= '0;
            rcnt_q   <= '0;
            algsel_q <= '0;
            test_q   <= 1'b0;
            ctl_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef MBIST_SCHED_WDOG_EN
            wdog_q   <= '0;
            tmo_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            cur_q    <= cur_d;
            fmap_q   <= fmap_d;
            rcnt_q   <= rcnt_d;
            algsel_q <= algsel_d;
            test_q   <= test_d;
            ctl_q    <= ctl_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef MBIST_SCHED_WDOG_EN
            wdog_q   <= wdog_d;
            tmo_q    <= tmo_d;
`endif
        end
    end

    assign test_h     = test_q;
    assign ctl_rst_l  = ctl_q;
    assign tst_algsel = algsel_q;
    assign busy       = busy_q;
    assign sess_done  = done_q;
    assign fail_map   = fmap_q;
`ifdef MBIST_SCHED_WDOG_EN
    assign timeout_err = tmo_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_mbist_alg_scheduler.sv
// Scoreboard bench for mbist_alg_scheduler: a controller model answers runs, a monitor checks runs and session results.
module tb_mbist_alg_scheduler;

    localparam int RST_CYC = 4;
`ifdef MBIST_SCHED_WDOG_EN
    localparam int TB_WDOG = 4;
`else
    localparam int TB_WDOG = 16;
`endif

    logic       bist_clk, rst_h, start_h, tst_done, fail_h;
    logic [3:0] alg_mask;
    logic       test_h, ctl_rst_l, busy, sess_done, timeout_err;
    logic [3:0] tst_algsel, fail_map;

    logic resp_done, resp_fail, stim_done, stim_fail;
    assign tst_done = resp_done | stim_done;
    assign fail_h   = resp_fail | stim_fail;

    mbist_alg_scheduler #(.ALGNUM(3), .RST_CYC(RST_CYC), .WDOG_W(TB_WDOG)) dut (
        .bist_clk(bist_clk), .rst_h(rst_h), .start_h(start_h), .alg_mask(alg_mask),
        .tst_done(tst_done), .fail_h(fail_h), .test_h(test_h), .ctl_rst_l(ctl_rst_l),
        .tst_algsel(tst_algsel), .busy(busy), .sess_done(sess_done),
        .fail_map(fail_map), .timeout_err(timeout_err)
    );

    initial begin
        bist_clk = 1'b0;
        forever #5 bist_clk = ~bist_clk;
    end

    typedef struct { logic [3:0] sel; int len; } run_t;
    typedef struct { logic [3:0] fmap; logic tmo; } done_t;
    run_t  run_q[$];
    done_t done_q[$];

    int tests = 0;
    int failed = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Controller model: tst_done on RUN cycle done_after (0 = never), fail_h on cycle fail_cycle of fail_sel.
    int         rc = 0;
    int         done_after = 10;
    int         fail_cycle = 0;
    logic [3:0] fail_sel = 4'b0000;
    always @(negedge bist_clk) begin
        if (test_h) rc++;
        else rc = 0;
        resp_done = test_h && (done_after != 0) && (rc == done_after);
        resp_fail = test_h && (tst_algsel == fail_sel) && (rc == fail_cycle);
    end

    // Monitor: checks each run (select, preceding reset length, length) and each session result.
    logic prev_test = 1'b0, prev_done = 1'b0, have_cur = 1'b0;
    int   streak = 0, runlen = 0;
    run_t cur_exp;
    always @(negedge bist_clk) begin
        if (!ctl_rst_l) streak++;
        if (test_h && !prev_test) begin
            runlen = 0;
            if (run_q.size() == 0) begin
                have_cur = 1'b0;
                check("unexpected_run", int'(tst_algsel), 0);
            end else begin
                cur_exp  = run_q.pop_front();
                have_cur = 1'b1;
                check("run_algsel", int'(tst_algsel), int'(cur_exp.sel));
                check("rst_low_cycles", streak, RST_CYC);
            end
        end
        if (test_h) runlen++;
        if (!test_h && prev_test && have_cur && cur_exp.len != 0)
            check("run_len", runlen, cur_exp.len);
        if (ctl_rst_l) streak = 0;
        if (sess_done && !prev_done) begin
            if (done_q.size() == 0) begin
                check("unexpected_done", int'(fail_map), -1);
            end else begin
                done_t e;
                e = done_q.pop_front();
                check("done_fail_map", int'(fail_map), int'(e.fmap));
                check("done_timeout", int'(timeout_err), int'(e.tmo));
            end
        end
        prev_test = test_h;
        prev_done = sess_done;
    end

    task automatic pulse_start(input logic [3:0] m);
        @(negedge bist_clk);
        start_h  = 1'b1;
        alg_mask = m;
        @(negedge bist_clk);
        start_h  = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!sess_done && n < 1000) begin
            @(negedge bist_clk);
            n++;
        end
        if (!sess_done) check("wait_done_timeout", 0, 1);
        @(negedge bist_clk);
    endtask

    task automatic wait_run(input logic [3:0] sel);
        int n = 0;
        while (!(test_h && tst_algsel == sel) && n < 500) begin
            @(negedge bist_clk);
            n++;
        end
        if (!(test_h && tst_algsel == sel)) check("wait_run_timeout", 0, 1);
    endtask

    initial begin
        rst_h = 1'b1; start_h = 1'b0; alg_mask = 4'b0000;
        stim_done = 1'b0; stim_fail = 1'b0;
        #1;
        check("reset_outputs", int'({test_h, ctl_rst_l, tst_algsel, busy, sess_done, fail_map, timeout_err}), 0);
        repeat (2) @(negedge bist_clk);
        rst_h = 1'b0;
        @(posedge bist_clk); #1;
        check("idle_ctl_rst_l_busy", int'({ctl_rst_l, busy, sess_done, test_h}), 4'b1000);

        // Two algorithms in order, no failures.
        run_q.push_back('{4'b0001, 10}); run_q.push_back('{4'b0100, 10});
        done_q.push_back('{4'b0000, 1'b0});
        pulse_start(4'b0101);
        wait_done();

        // All four algorithms, one-cycle fail in the middle of algorithm 2.
        fail_sel = 4'b0100; fail_cycle = 5;
        for (int i = 0; i < 4; i++) run_q.push_back('{4'(1 << i), 10});
        done_q.push_back('{4'b0100, 1'b0});
        pulse_start(4'b1111);
        wait_done();

        // fail_h on the same edge as tst_done still counts.
        fail_sel = 4'b1000; fail_cycle = 10;
        run_q.push_back('{4'b1000, 10});
        done_q.push_back('{4'b1000, 1'b0});
        pulse_start(4'b1000);
        wait_done();
        fail_sel = 4'b0000; fail_cycle = 0;

        // Controller strobes while in DONE are ignored.
        @(negedge bist_clk); stim_done = 1'b1; stim_fail = 1'b1;
        @(negedge bist_clk); stim_done = 1'b0; stim_fail = 1'b0;
        @(negedge bist_clk);
        check("done_ignores_ctl", int'({sess_done, busy, test_h, fail_map}), 7'b100_1000);

        // Restart from DONE clears results; start_h and alg_mask changes mid-session have no effect.
        run_q.push_back('{4'b0001, 10}); run_q.push_back('{4'b0100, 10});
        done_q.push_back('{4'b0000, 1'b0});
        pulse_start(4'b0101);
        alg_mask = 4'b1010;
        wait_run(4'b0001);
        pulse_start(4'b1111);
        alg_mask = 4'b1010;
        wait_done();

        // Reset during the run of algorithm 1 aborts the session.
        run_q.push_back('{4'b0001, 10}); run_q.push_back('{4'b0010, 0});
        pulse_start(4'b0011);
        wait_run(4'b0010);
        repeat (3) @(negedge bist_clk);
        rst_h = 1'b1;
        #1;
        check("abort_reset_outputs", int'({test_h, ctl_rst_l, tst_algsel, busy, sess_done, fail_map, timeout_err}), 0);
        repeat (2) @(negedge bist_clk);
        rst_h = 1'b0;
        repeat (30) @(negedge bist_clk);
        check("abort_stays_idle", int'({ctl_rst_l, busy, sess_done, test_h, tst_algsel}), 8'b1000_0000);

        // tst_done in IDLE is ignored.
        stim_done = 1'b1; stim_fail = 1'b1;
        @(negedge bist_clk); stim_done = 1'b0; stim_fail = 1'b0;
        @(negedge bist_clk);
        check("idle_ignores_ctl", int'({busy, sess_done, fail_map}), 0);

        // Empty mask goes straight to DONE without a run.
        done_q.push_back('{4'b0000, 1'b0});
        @(negedge bist_clk);
        start_h = 1'b1; alg_mask = 4'b0000;
        @(posedge bist_clk); #1;
        check("empty_mask_done", int'({sess_done, test_h, busy}), 3'b100);
        @(negedge bist_clk);
        start_h = 1'b0;
        repeat (3) @(negedge bist_clk);

`ifdef MBIST_SCHED_WDOG_EN
        // Watchdog: controller never finishes.
        done_after = 0;
        run_q.push_back('{4'b0001, 15});
        done_q.push_back('{4'b0001, 1'b1});
        pulse_start(4'b0001);
        wait_done();
        done_after = 10;
`endif

        repeat (3) @(negedge bist_clk);
        check("runs_outstanding", run_q.size(), 0);
        check("results_outstanding", done_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/mbist_alg_scheduler.md
MBIST_ALG_SCHEDULER -- requirements
Module: mbist_alg_scheduler

Interface
REQ-001 The block SHALL have parameter ALGNUM, default 3, giving the algorithm bus width (bus [ALGNUM:0], 4 algorithms).
REQ-002 The block SHALL have parameter RST_CYC, default 4, giving the number of cycles the controller reset is held per run (legal range 1..15).
REQ-003 The block SHALL have parameter WDOG_W, default 16, giving the watchdog counter width.
REQ-004 Port bist_clk, input, 1: the only clock; all state changes on its rising edge.
REQ-005 Port rst_h, input, 1: asynchronous, active-high reset.
REQ-006 Port start_h, input, 1: session start request, sampled only in IDLE or DONE.
REQ-007 Port alg_mask, input, [ALGNUM:0]: algorithms to run, bitwise, sampled with start_h.
REQ-008 Port tst_done, input, 1: run-complete from the MBIST controller.
REQ-009 Port fail_h, input, 1: fail flag from the MBIST controller.
REQ-010 Port test_h, output, 1: test enable to the controller.
REQ-011 Port ctl_rst_l, output, 1: active-low reset to the controller.
REQ-012 Port tst_algsel, output, [ALGNUM:0]: one-hot algorithm select to the controller.
REQ-013 Port busy, output, 1: high in RST, RUN and LOG.
REQ-014 Port sess_done, output, 1: high while in DONE.
REQ-015 Port fail_map, output, [ALGNUM:0]: per-algorithm fail result; bit i set means algorithm i failed.
REQ-016 Port timeout_err, output, 1: sticky flag, set when any run hit the watchdog.

Function
REQ-017 The FSM SHALL have states IDLE, RST, RUN, LOG and DONE; IDLE is entered on reset.
REQ-018 In IDLE or DONE, start_h=1 with alg_mask!=0 SHALL:
- latch alg_mask into a pending register;
- clear fail_map and timeout_err;
- select the lowest set pending bit as current;
- enter RST on the next edge.
REQ-019 In IDLE or DONE, start_h=1 with alg_mask==0 SHALL enter DONE with fail_map=0; no controller run occurs.
REQ-020 RST SHALL drive ctl_rst_l=0 and test_h=0 for exactly RST_CYC cycles, then enter RUN.
REQ-021 RUN SHALL drive ctl_rst_l=1 and test_h=1; the first RUN cycle is RST_CYC+1 cycles after the start_h edge.
REQ-022 tst_algsel SHALL be one-hot on the current algorithm throughout RST, RUN and LOG, and all-zero in IDLE and DONE.
REQ-023 During each RUN cycle, fail_map[current] SHALL be OR-ed with fail_h (sticky within the session).
REQ-024 RUN SHALL move to LOG on the edge where tst_done=1; fail_h sampled on that same edge SHALL be included.
REQ-025 LOG SHALL last one cycle with test_h=0, ctl_rst_l=1, and SHALL clear the current bit from pending.
REQ-026 From LOG, if pending is nonzero, the block SHALL select the next lowest set bit and enter RST; otherwise it SHALL enter DONE.
REQ-027 DONE SHALL hold sess_done=1, fail_map and timeout_err stable until the next accepted start_h.
REQ-028 start_h SHALL be ignored while busy=1; alg_mask changes during a session SHALL have no effect.
REQ-029 tst_done or fail_h asserted outside RUN SHALL be ignored.

Reset
REQ-030 rst_h=1 SHALL immediately force:
- state IDLE;
- test_h=0, ctl_rst_l=0, tst_algsel=0;
- busy=0, sess_done=0, fail_map=0, timeout_err=0;
- pending=0 and all counters=0.
REQ-031 Reset asserted mid-session SHALL abort the session; after release the block waits in IDLE and resumes nothing.
REQ-032 ctl_rst_l SHALL be 1 in IDLE after reset release.

Configuration
REQ-033 With macro MBIST_SCHED_WDOG_EN defined, the block SHALL include a watchdog:
- a WDOG_W-bit counter cleared on RUN entry and incremented each RUN cycle;
- on reaching all-ones with tst_done=0, it SHALL set fail_map[current] and timeout_err, then enter LOG;
- if tst_done=1 on the terminal cycle, tst_done wins and timeout_err is not set.
REQ-034 Without MBIST_SCHED_WDOG_EN, no watchdog logic SHALL exist, timeout_err SHALL be tied 0, and RUN waits indefinitely for tst_done.

Verification
REQ-035 alg_mask=4'b0101, start_h pulse, tst_done after 10 RUN cycles, fail_h=0 -> runs in order algsel 0001 then 0100; ctl_rst_l low 4 cycles before each run; DONE with fail_map=0000.
REQ-036 alg_mask=4'b1111, fail_h pulsed one cycle mid-RUN of algorithm 2 only -> fail_map=4'b0100 in DONE.
REQ-037 alg_mask=0 with start_h -> DONE next edge, fail_map=0, test_h never asserted.
REQ-038 rst_h asserted during the RUN of algorithm 1 of mask 4'b0011 -> all outputs reset immediately; IDLE; no further runs until a new start_h.
REQ-039 MBIST_SCHED_WDOG_EN defined, WDOG_W=4, tst_done never asserted for mask 4'b0001 -> LOG after 15 RUN cycles; fail_map=0001; timeout_err=1.
REQ-040 start_h re-pulsed while busy, and tst_done pulsed in IDLE -> no effect on state, pending or fail_map.
